spi_master_frame: RTL and testbench
===================================

SPI_MASTER_FRAME -- requirements
Module: spi_master_frame

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk cycles per SLCK half-period; legal values are 1 or more.
REQ-002 Parameter: CS_GAP, default 2, clk cycles CS stays high after a frame before done; legal values are 1 or more.
REQ-003 Port: clk  input  1  system clock; the only clock, and all logic is on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset; it is sampled on the clk rising edge.
REQ-005 Port: start  input  1  request to send one frame.
REQ-006 Port: tx_data  input  8  frame to transmit, MSB first.
REQ-007 Port: MISO  input  1  serial data from the slave.
REQ-008 Port: CS  output  1  active-low slave select.
REQ-009 Port: SLCK  output  1  serial clock to the slave.
REQ-010 Port: MOSI  output  1  serial data to the slave.
REQ-011 Port: rx_data  output  8  last complete received frame.
REQ-012 Port: busy  output  1  high while a frame is in progress.
REQ-013 Port: done  output  1  one-cycle pulse when a frame completes.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The block SHALL drive SPI mode 0: SLCK idles low, MOSI changes only while SLCK is low, and the slave samples on the SLCK rising edge.
REQ-016 States SHALL be IDLE, SETUP, HIGH, LOW, HOLD and GAP.
REQ-017 IDLE: CS=1, SLCK=0, busy=0; start=1 is accepted at the clk edge, loading tx_data into the shift register, setting CS=0, MOSI=tx_data[7], busy=1, and moving to SETUP.
REQ-018 SETUP: the block SHALL wait CLK_DIV cycles, then set SLCK=1 and move to HIGH.
REQ-019 HIGH: after CLK_DIV cycles, at its final edge, the block SHALL shift MISO into the rx shift register LSB (sampling MSB first) and set SLCK=0.
REQ-020 At the end of HIGH, if fewer than 8 bits are done, the block SHALL present the next MOSI bit and move to LOW; otherwise it SHALL move to HOLD.
REQ-021 LOW: after CLK_DIV cycles, the block SHALL set SLCK=1 and move to HIGH.
REQ-022 HOLD: the block SHALL keep SLCK=0 and CS=0 for CLK_DIV cycles, then set CS=1 and move to GAP.
REQ-023 GAP: after CS_GAP cycles, the block SHALL update rx_data from the shift register, pulse done=1 for exactly one cycle, set busy=0 and move to IDLE.
REQ-024 Each frame SHALL contain exactly 8 SLCK rising edges.
REQ-025 Frame timing: SETUP + 8 HIGH + 7 LOW + HOLD phases take 17*CLK_DIV cycles.
REQ-026 done SHALL rise 17*CLK_DIV+CS_GAP cycles after the start-accept edge, which is 70 cycles at the default parameters.
REQ-027 start SHALL be ignored while busy=1, and tx_data changes during a frame SHALL have no effect.
REQ-028 start=1 in the same cycle as done SHALL be accepted, because the block is in IDLE that cycle; there is no extra gap beyond CS_GAP.
REQ-029 rx_data SHALL hold its value between done pulses and SHALL change only on the done edge.
REQ-030 MOSI SHALL be 0 in IDLE.
REQ-031 CS SHALL never glitch low outside a frame.
REQ-032 SLCK SHALL be 0 whenever CS=1.
REQ-033 The bit counter SHALL be 3 bits, counting 0..7, and SHALL never wrap within a frame.

Reset
REQ-034 When rst=0 at a clk edge, the block SHALL go to IDLE with CS=1, SLCK=0, MOSI=0, busy=0, done=0, rx_data=8'h00 and all counters cleared.
REQ-035 Reset mid-frame SHALL abort the frame immediately, producing no done pulse and leaving rx_data at 8'h00.
REQ-036 Reset SHALL take priority over start in the same cycle.

Verification
REQ-037 Loopback test: with MISO tied to MOSI and default parameters, start with tx_data=8'hA5 -> MOSI sampled at SLCK rising edges reads 1,0,1,0,0,1,0,1; rx_data=8'hA5; done rises 70 cycles after accept.
REQ-038 Constant MISO test: MISO=1 gives rx_data=8'hFF, and MISO=0 gives rx_data=8'h00; in both cases exactly 8 SLCK rising edges occur and busy is high for 70 cycles.
REQ-039 Ignored start test: pulse start with tx_data=8'h3C at cycle 10 of a frame carrying 8'hA5 -> the frame still transmits 8'hA5, and a single done pulse follows.
REQ-040 Reset mid-frame test: assert rst=0 during the 4th HIGH phase -> the next cycle shows CS=1, SLCK=0, busy=0 and rx_data=8'h00; no done pulse occurs; a new frame then runs normally.
REQ-041 Back-to-back test: assert start in the done cycle -> the second frame starts on the next edge, and CS stays high for exactly CS_GAP+1 cycles between frames.
REQ-042 Minimum-divider test: with CLK_DIV=1 and CS_GAP=1, loopback 8'h5A -> rx_data=8'h5A, and done rises 18 cycles after accept.

Source files
------------

// File: rtl/spi_master_frame.sv
// spi_master_frame: single-byte SPI mode-0 master with framed chip select.
// Sends tx_data MSB first, captures MISO into rx_data, pulses done per frame.
module spi_master_frame #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       MISO,
    output logic       CS,
    output logic       SLCK,
    output logic       MOSI,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          cs_q, cs_d;
    logic          slck_q, slck_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Frame sequencer: phase timing, shifting and next-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cs_d      = cs_q;
        slck_d    = slck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (start) begin
                    tx_sh_d = tx_data;
                    cs_d    = 1'b0;
                    mosi_d  = tx_data[7];
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    slck_d  = 1'b1;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    rx_sh_d = {rx_sh_q[6:0], MISO};
                    slck_d  = 1'b0;
                    if (bit_q != 3'd7) begin
                        // Next bit goes out while SLCK is low.
                        bit_d   = bit_q + 3'd1;
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        mosi_d  = tx_sh_q[6];
                        state_d = LOW;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    slck_d  = 1'b1;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d     = '0;
                    bit_d     = 3'd0;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cs_d    = 1'b1;
                slck_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            cs_q      <= 1'b1;
            slck_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cs_q      <= cs_d;
            slck_q    <= slck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CS      = cs_q;
    assign SLCK    = slck_q;
    assign MOSI    = mosi_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_master_frame.sv
// tb_spi_master_frame: directed checks of the SPI frame master.
// Default instance plus a CLK_DIV=1/CS_GAP=1 loopback instance.
module tb_spi_master_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start2, loop, miso_c;
    logic [7:0] tx_data, tx2;
    logic       miso1, cs1, slck1, mosi1, busy1, done1;
    logic       miso2, cs2, slck2, mosi2, busy2, done2;
    logic [7:0] rx1, rx2;

    int checks = 0;
    int fails  = 0;

    assign miso1 = loop ? mosi1 : miso_c;
    assign miso2 = mosi2;

    spi_master_frame dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .MISO(miso1), .CS(cs1), .SLCK(slck1), .MOSI(mosi1),
        .rx_data(rx1), .busy(busy1), .done(done1)
    );

    spi_master_frame #(.CLK_DIV(1), .CS_GAP(1)) dut_min (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2),
        .MISO(miso2), .CS(cs2), .SLCK(slck2), .MOSI(mosi2),
        .rx_data(rx2), .busy(busy2), .done(done2)
    );

    // Runs one frame on the default instance, sampling at negedges.
    // Sample n follows the n-th edge after the accept edge (n=0).
    task automatic run_frame(
        input  logic [7:0] tx,
        input  int         inj,
        input  logic [7:0] inj_tx,
        input  bit         chain,
        input  logic [7:0] chain_tx,
        input  bit         pre_started,
        output int         lat,
        output logic [7:0] bits,
        output int         rises,
        output int         busy_n,
        output int         done_n,
        output int         cs_hi,
        output int         viol
    );
        logic prev_s, prev_m;
        lat = -1; bits = 8'h00; rises = 0; busy_n = 0;
        done_n = 0; cs_hi = 0; viol = 0;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1; tx_data = tx;
        end
        @(negedge clk);
        start = 1'b0; tx_data = ~tx;
        prev_s = 1'b0; prev_m = mosi1;
        for (int n = 0; n < 300; n++) begin
            if (n > 0) @(negedge clk);
            start = 1'b0;
            if (busy1) busy_n++;
            if (cs1) cs_hi++;
            if (slck1 && !prev_s) begin
                rises++;
                bits = {bits[6:0], mosi1};
            end
            if (slck1 && prev_s && mosi1 !== prev_m) viol++;
            prev_s = slck1; prev_m = mosi1;
            if (done1) begin
                done_n++;
                if (lat < 0) lat = n;
                if (chain) begin
                    start = 1'b1; tx_data = chain_tx;
                    break;
                end
            end
            if (n == inj) begin
                start = 1'b1; tx_data = inj_tx;
            end
            if (lat >= 0 && n >= lat + 2) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cs1 !== 1'b1) begin fails++; $display("FAIL reset_cs got %b want 1", cs1); end
        checks++; if (slck1 !== 1'b0) begin fails++; $display("FAIL reset_slck got %b want 0", slck1); end
        checks++; if (mosi1 !== 1'b0) begin fails++; $display("FAIL reset_mosi got %b want 0", mosi1); end
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy1, done1); end
        checks++; if (rx1 !== 8'h00) begin fails++; $display("FAIL reset_rx got %h want 00", rx1); end
        // Reset wins over a simultaneous start.
        start = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        checks++; if (cs1 !== 1'b1 || busy1 !== 1'b0) begin fails++; $display("FAIL reset_prio cs/busy got %b%b want 10", cs1, busy1); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cs1 !== 1'b1 || mosi1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL idle cs/mosi/busy got %b%b%b want 100", cs1, mosi1, busy1); end
    endtask

    task automatic test_loopback();
        int lat, rises, busy_n, done_n, cs_hi, viol;
        logic [7:0] bits;
        loop = 1'b1;
        run_frame(8'hA5, -1, 8'h00, 1'b0, 8'h00, 1'b0,
                  lat, bits, rises, busy_n, done_n, cs_hi, viol);
        checks++; if (bits !== 8'hA5) begin fails++; $display("FAIL loop_mosi_bits got %h want a5", bits); end
        checks++; if (rx1 !== 8'hA5) begin fails++; $display("FAIL loop_rx got %h want a5", rx1); end
        checks++; if (lat !== 70) begin fails++; $display("FAIL loop_latency got %0d want 70", lat); end
        checks++; if (rises !== 8) begin fails++; $display("FAIL loop_rises got %0d want 8", rises); end
        checks++; if (viol !== 0) begin fails++; $display("FAIL loop_mode0 mosi changes in high got %0d want 0", viol); end
        checks++; if (done_n !== 1) begin fails++; $display("FAIL loop_done_count got %0d want 1", done_n); end
        // rx_data holds between frames.
        repeat (5) @(negedge clk);
        checks++; if (rx1 !== 8'hA5) begin fails++; $display("FAIL loop_rx_hold got %h want a5", rx1); end
    endtask

    task automatic test_const_miso();
        int lat, rises, busy_n, done_n, cs_hi, viol;
        logic [7:0] bits;
        loop = 1'b0;
        miso_c = 1'b1;
        run_frame(8'h12, -1, 8'h00, 1'b0, 8'h00, 1'b0,
                  lat, bits, rises, busy_n, done_n, cs_hi, viol);
        checks++; if (rx1 !== 8'hFF) begin fails++; $display("FAIL miso1_rx got %h want ff", rx1); end
        checks++; if (rises !== 8) begin fails++; $display("FAIL miso1_rises got %0d want 8", rises); end
        checks++; if (busy_n !== 70) begin fails++; $display("FAIL miso1_busy got %0d want 70", busy_n); end
        checks++; if (bits !== 8'h12) begin fails++; $display("FAIL miso1_mosi_bits got %h want 12", bits); end
        miso_c = 1'b0;
        run_frame(8'hED, -1, 8'h00, 1'b0, 8'h00, 1'b0,
                  lat, bits, rises, busy_n, done_n, cs_hi, viol);
        checks++; if (rx1 !== 8'h00) begin fails++; $display("FAIL miso0_rx got %h want 00", rx1); end
        checks++; if (rises !== 8) begin fails++; $display("FAIL miso0_rises got %0d want 8", rises); end
        checks++; if (busy_n !== 70) begin fails++; $display("FAIL miso0_busy got %0d want 70", busy_n); end
        loop = 1'b1;
    endtask

    task automatic test_ignored_start();
        int lat, rises, busy_n, done_n, cs_hi, viol;
        logic [7:0] bits;
        run_frame(8'hA5, 10, 8'h3C, 1'b0, 8'h00, 1'b0,
                  lat, bits, rises, busy_n, done_n, cs_hi, viol);
        checks++; if (bits !== 8'hA5) begin fails++; $display("FAIL ign_mosi_bits got %h want a5", bits); end
        checks++; if (rx1 !== 8'hA5) begin fails++; $display("FAIL ign_rx got %h want a5", rx1); end
        checks++; if (done_n !== 1) begin fails++; $display("FAIL ign_done_count got %0d want 1", done_n); end
        checks++; if (lat !== 70) begin fails++; $display("FAIL ign_latency got %0d want 70", lat); end
        repeat (3) @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL ign_no_second_frame busy got %b want 0", busy1); end
    endtask

    task automatic test_reset_mid();
        int lat, rises, busy_n, done_n, cs_hi, viol;
        int dn;
        logic [7:0] bits;
        @(negedge clk);
        start = 1'b1; tx_data = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        checks++; if (slck1 !== 1'b1) begin fails++; $display("FAIL mid_in_high slck got %b want 1", slck1); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cs1 !== 1'b1 || slck1 !== 1'b0 || busy1 !== 1'b0) begin fails++; $display("FAIL mid_abort cs/slck/busy got %b%b%b want 100", cs1, slck1, busy1); end
        checks++; if (rx1 !== 8'h00) begin fails++; $display("FAIL mid_rx got %h want 00", rx1); end
        rst = 1'b1;
        dn = 0;
        repeat (100) begin
            @(negedge clk);
            if (done1) dn++;
        end
        checks++; if (dn !== 0) begin fails++; $display("FAIL mid_no_done got %0d want 0", dn); end
        run_frame(8'h96, -1, 8'h00, 1'b0, 8'h00, 1'b0,
                  lat, bits, rises, busy_n, done_n, cs_hi, viol);
        checks++; if (rx1 !== 8'h96) begin fails++; $display("FAIL mid_next_rx got %h want 96", rx1); end
        checks++; if (lat !== 70) begin fails++; $display("FAIL mid_next_latency got %0d want 70", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, rises, busy_n, done_n, cs_hi, viol;
        logic [7:0] bits;
        run_frame(8'hC3, -1, 8'h00, 1'b1, 8'h69, 1'b0,
                  lat, bits, rises, busy_n, done_n, cs_hi, viol);
        checks++; if (rx1 !== 8'hC3) begin fails++; $display("FAIL b2b_first_rx got %h want c3", rx1); end
        checks++; if (cs_hi !== 3) begin fails++; $display("FAIL b2b_cs_high got %0d want 3", cs_hi); end
        run_frame(8'h69, -1, 8'h00, 1'b0, 8'h00, 1'b1,
                  lat, bits, rises, busy_n, done_n, cs_hi, viol);
        checks++; if (lat !== 70) begin fails++; $display("FAIL b2b_second_latency got %0d want 70", lat); end
        checks++; if (rx1 !== 8'h69) begin fails++; $display("FAIL b2b_second_rx got %h want 69", rx1); end
        checks++; if (bits !== 8'h69) begin fails++; $display("FAIL b2b_second_bits got %h want 69", bits); end
    endtask

    task automatic test_min_div();
        int lat;
        lat = -1;
        @(negedge clk);
        start2 = 1'b1; tx2 = 8'h5A;
        @(negedge clk);
        start2 = 1'b0; tx2 = 8'h00;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge clk);
            if (done2) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== 18) begin fails++; $display("FAIL min_latency got %0d want 18", lat); end
        checks++; if (rx2 !== 8'h5A) begin fails++; $display("FAIL min_rx got %h want 5a", rx2); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        tx_data = 8'h00; tx2 = 8'h00;
        loop = 1'b1; miso_c = 1'b0;
        test_reset();
        test_loopback();
        test_const_miso();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_min_div();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
